// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin I/D-cache line-port arbiter with response watchdog
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req,
  input  logic [ADDR_WIDTH-1:0] ic_addr,
  output logic                  ic_rvalid,
  output logic [LINE_WIDTH-1:0] ic_rdata,
  output logic                  ic_stall,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [ADDR_WIDTH-1:0] dc_addr,
  input  logic [LINE_WIDTH-1:0] dc_wdata,
  output logic                  dc_rvalid,
  output logic [LINE_WIDTH-1:0] dc_rdata,
  output logic                  dc_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic                  timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CYCLES);

  logic [1:0]            state;
  logic                  owner;
  logic                  last_owner;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [LINE_WIDTH-1:0] ic_rdata_q;
  logic [LINE_WIDTH-1:0] dc_rdata_q;
  logic [CW-1:0]         wd_cnt;
  logic [CW-1:0]         wd_next;
  logic                  timeout_q;

  logic                  grant_valid;
  logic                  grant_owner;
  logic                  grant_we;

  // Round-robin pick: on a tie the requester that did not win last time goes next
  always_comb begin
    grant_valid = ic_req | dc_req;
    grant_owner = OWN_DC;
    if (ic_req && dc_req) begin
      grant_owner = ~last_owner;
    end else if (ic_req) begin
      grant_owner = OWN_IC;
    end
    grant_we = (grant_owner == OWN_DC) & dc_we;
    wd_next  = wd_cnt + CW'(1);
  end

  // IDLE -> BUSY -> RESP transaction sequencer with watchdog abort
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWN_IC;
      last_owner <= OWN_DC;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      wd_cnt     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            owner      <= grant_owner;
            last_owner <= grant_owner;
            addr_q     <= (grant_owner == OWN_IC) ? ic_addr : dc_addr;
            we_q       <= grant_we;
            wdata_q    <= grant_we ? dc_wdata : '0;
            wd_cnt     <= '0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            if (owner == OWN_IC) begin
              ic_rdata_q <= mem_rdata;
            end else begin
              dc_rdata_q <= we_q ? '0 : mem_rdata;
            end
            state <= S_RESP;
          end else if (wd_next == WD_LIMIT) begin
            // Memory never answered: report it and release the requester with a zero line
            timeout_q <= 1'b1;
            if (owner == OWN_IC) begin
              ic_rdata_q <= '0;
            end else begin
              dc_rdata_q <= '0;
            end
            state <= S_RESP;
          end else begin
            wd_cnt <= wd_next;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req     = (state == S_BUSY);
  assign mem_we      = (state == S_BUSY) & we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign ic_rvalid   = (state == S_RESP) & (owner == OWN_IC);
  assign dc_rvalid   = (state == S_RESP) & (owner == OWN_DC);
  assign ic_rdata    = ic_rdata_q;
  assign dc_rdata    = dc_rdata_q;
  assign ic_stall    = ic_req & ~ic_rvalid;
  assign dc_stall    = dc_req & ~dc_rvalid;
  assign timeout_err = timeout_q;

endmodule
